// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer
//   Issuing/collecting end of a 32-bit combinational ALU. One tagged request
//   is accepted over valid/ready, and its operands are registered and driven
//   to the ALU. After a fixed settle time the ALU result and flags are
//   captured and returned over valid/ready, together with the tag and a
//   divide-by-zero error bit. Two status registers are kept for software
//   polling: a sticky carry/borrow flag and a count of completed operations.
//
// Ports
//   clk, rst_n                      clock (rising edge), async active-low reset
//   req_valid/req_ready             request handshake
//   req_sel, req_a, req_b, req_tag  request op code, operands and tag
//   alu_a, alu_b, alu_sel           registered operands driven to the ALU
//   alu_out, alu_c, alu_z, alu_n    ALU result and flags
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_flags, rsp_err    captured result, {c,z,n} and divide-by-zero
//   rsp_tag                         tag of the answered request
//   stat_clr                        clears sticky_c (a simultaneous set wins)
//   sticky_c                        OR of captured carry over add/sub responses
//   op_count                        completed responses, wraps
module alu_req_sequencer #(
    parameter int SETTLE_CYC = 1,
    parameter int MD_EXTRA   = 2,
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_sel,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_sel,
    input  logic [31:0]      alu_out,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    input  logic             stat_clr,
    output logic             sticky_c,
    output logic [CNT_W-1:0] op_count
);

    localparam int CNT_MAX = SETTLE_CYC - 1 + MD_EXTRA;
    localparam int CW      = $clog2(CNT_MAX + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [TAG_W-1:0]  tag_p0;
    logic              capture;
    logic              c_set;

    // Settle countdown start value: mul (110) and div (111) need extra cycles.
    function automatic logic [CW-1:0] settle_load(input logic [2:0] sel);
        if (sel[2:1] == 2'b11)
            return CW'(SETTLE_CYC - 1 + MD_EXTRA);
        else
            return CW'(SETTLE_CYC - 1);
    endfunction

    assign capture = (state == EXEC) && (cnt == '0);
    // Only add (100) and sub (101) contribute to the sticky carry/borrow.
    assign c_set   = capture && (alu_sel[2:1] == 2'b10) && alu_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            cnt       <= '0;
            tag_p0    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
            sticky_c  <= 1'b0;
            op_count  <= '0;
        end else begin
            // Set takes priority over a same-cycle clear.
            if (c_set)
                sticky_c <= 1'b1;
            else if (stat_clr)
                sticky_c <= 1'b0;

            case (state)
                // Stage p0: accept and register the request operands.
                IDLE: begin
                    if (req_valid) begin
                        alu_a     <= req_a;
                        alu_b     <= req_b;
                        alu_sel   <= req_sel;
                        tag_p0    <= req_tag;
                        cnt       <= settle_load(req_sel);
                        req_ready <= 1'b0;
                        state     <= EXEC;
                    end
                end
                // Stage p1: hold operands while the ALU settles, then capture.
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_data  <= alu_out;
                        rsp_flags <= {alu_c, alu_z, alu_n};
                        rsp_err   <= (alu_sel == 3'b111) && (alu_b == 32'd0);
                        rsp_tag   <= tag_p0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                // Stage p2: present the response until the consumer takes it.
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        op_count  <= op_count + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
module tb_alu_req_sequencer;

    localparam int SETTLE_CYC = 1;
    localparam int MD_EXTRA   = 2;
    localparam int TAG_W      = 4;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_sel = '0;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_sel;
    logic [31:0]      alu_out;
    logic             alu_c;
    logic             alu_z;
    logic             alu_n;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_data;
    logic [2:0]       rsp_flags;
    logic             rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic             stat_clr = 1'b0;
    logic             sticky_c;
    logic [CNT_W-1:0] op_count;

    alu_req_sequencer #(
        .SETTLE_CYC(SETTLE_CYC),
        .MD_EXTRA  (MD_EXTRA),
        .TAG_W     (TAG_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_sel  (req_sel),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_tag  (req_tag),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_sel  (alu_sel),
        .alu_out  (alu_out),
        .alu_c    (alu_c),
        .alu_z    (alu_z),
        .alu_n    (alu_n),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_flags(rsp_flags),
        .rsp_err  (rsp_err),
        .rsp_tag  (rsp_tag),
        .stat_clr (stat_clr),
        .sticky_c (sticky_c),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU: returns {out, c, z, n}.
    function automatic logic [34:0] alu_f(input logic [2:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] o;
        logic        c;
        c = 1'b0;
        case (sel)
            3'b000: o = ~a;
            3'b001: o = a | b;
            3'b010: o = a & b;
            3'b011: o = a ^ b;
            3'b100: begin w = {1'b0, a} + {1'b0, b}; o = w[31:0]; c = w[32]; end
            3'b101: begin w = {1'b0, a} - {1'b0, b}; o = w[31:0]; c = w[32]; end
            3'b110: o = a * b;
            default: o = (b == 32'd0) ? 32'd0 : a / b;
        endcase
        return {o, c, (o == 32'd0), o[31]};
    endfunction

    assign {alu_out, alu_c, alu_z, alu_n} = alu_f(alu_sel, alu_a, alu_b);

    typedef struct packed {
        logic [31:0]      data;
        logic [2:0]       flags;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic issue(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input bit clr_at_capture);
        logic [34:0] r;
        exp_t        e;
        int          n;
        int          lat;
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = sel;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
            errors++;
            req_valid = 1'b0;
            return;
        end
        r       = alu_f(sel, a, b);
        e.data  = r[34:3];
        e.flags = r[2:0];
        e.err   = (sel == 3'b111) && (b == 32'd0);
        e.tag   = tag;
        sb.push_back(e);
        lat = SETTLE_CYC + ((sel[2:1] == 2'b11) ? MD_EXTRA : 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_sel   = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        req_tag   = TAG_W'($urandom);
        checks++;
        if ({alu_sel, alu_a, alu_b} !== {sel, a, b} || req_ready !== 1'b0) begin
            $display("FAIL exec_operands: sel=%h a=%h b=%h ready=%b required sel=%h a=%h b=%h ready=0",
                     alu_sel, alu_a, alu_b, req_ready, sel, a, b);
            errors++;
        end
        if (clr_at_capture) stat_clr = 1'b1;
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
            stat_clr = 1'b0;
        end
        stat_clr = 1'b0;
        checks++;
        if (n != lat + 1) begin
            $display("FAIL latency: observed %0d edges required %0d", n - 1, lat);
            errors++;
        end
    endtask

    task automatic collect(input int hold);
        exp_t        e;
        logic [31:0] d0;
        int          n;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
            errors++;
            return;
        end
        d0 = rsp_data;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d0 || req_ready !== 1'b0 || op_count !== exp_cnt) begin
                $display("FAIL hold: valid=%b data=%h ready=%b cnt=%0d required 1 %h 0 %0d",
                         rsp_valid, rsp_data, req_ready, op_count, d0, exp_cnt);
                errors++;
            end
        end
        rsp_ready = 1'b1;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL scoreboard_empty: got data=%h required a pending entry", rsp_data);
            errors++;
        end else begin
            e = sb.pop_front();
            if (rsp_data !== e.data || rsp_flags !== e.flags || rsp_err !== e.err || rsp_tag !== e.tag) begin
                $display("FAIL response: data=%h flags=%b err=%b tag=%h required data=%h flags=%b err=%b tag=%h",
                         rsp_data, rsp_flags, rsp_err, rsp_tag, e.data, e.flags, e.err, e.tag);
                errors++;
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_cnt   = exp_cnt + 1'b1;
        checks++;
        if (rsp_valid !== 1'b0 || op_count !== exp_cnt || req_ready !== 1'b1) begin
            $display("FAIL handshake: valid=%b cnt=%0d ready=%b required 0 %0d 1",
                     rsp_valid, op_count, req_ready, exp_cnt);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_tag, alu_a, alu_b, alu_sel, sticky_c, op_count} !== '0) begin
            $display("FAIL reset_outputs: valid=%b data=%h flags=%b err=%b tag=%h a=%h b=%h sel=%h sticky=%b cnt=%0d required all 0",
                     rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_tag, alu_a, alu_b, alu_sel, sticky_c, op_count);
            errors++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
            errors++;
        end
        exp_cnt = '0;
        sb.delete();
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        req_valid = 1'b1;
        req_sel   = 3'b110;
        req_a     = 32'd3;
        req_b     = 32'd4;
        req_tag   = 4'h9;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (alu_a !== 32'd3 || req_ready !== 1'b0) begin
            $display("FAIL mid_accept: alu_a=%h ready=%b required 3 0", alu_a, req_ready);
            errors++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({rsp_valid, rsp_data, alu_a, alu_b, alu_sel, op_count} !== '0 || req_ready !== 1'b1) begin
            $display("FAIL mid_reset_outputs: valid=%b data=%h a=%h b=%h sel=%h cnt=%0d ready=%b required zeros, ready 1",
                     rsp_valid, rsp_data, alu_a, alu_b, alu_sel, op_count, req_ready);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                $display("FAIL mid_reset_no_rsp: cycle %0d rsp_valid=%b required 0", i, rsp_valid);
                errors++;
            end
        end
        issue(3'b110, 32'd3, 32'd4, 4'h9, 1'b0);
        collect(0);
    endtask

    task automatic test_add();
        issue(3'b100, 32'hFFFF_FFFF, 32'd1, 4'h1, 1'b0);
        checks++;
        if (rsp_data !== 32'd0 || rsp_flags !== 3'b110 || sticky_c !== 1'b1) begin
            $display("FAIL add_carry: data=%h flags=%b sticky=%b required 0 110 1", rsp_data, rsp_flags, sticky_c);
            errors++;
        end
        collect(0);
        issue(3'b011, 32'h8000_00AA, 32'h0000_00AA, 4'h2, 1'b0);
        collect(0);
    endtask

    task automatic test_div0();
        issue(3'b111, 32'd7, 32'd0, 4'h5, 1'b0);
        checks++;
        if (rsp_data !== 32'd0 || rsp_err !== 1'b1 || rsp_flags !== 3'b010 || rsp_tag !== 4'h5) begin
            $display("FAIL div_zero: data=%h err=%b flags=%b tag=%h required 0 1 010 5",
                     rsp_data, rsp_err, rsp_flags, rsp_tag);
            errors++;
        end
        collect(0);
        issue(3'b111, 32'd100, 32'd7, 4'hA, 1'b0);
        checks++;
        if (rsp_data !== 32'd14 || rsp_err !== 1'b0) begin
            $display("FAIL div_normal: data=%0d err=%b required 14 0", rsp_data, rsp_err);
            errors++;
        end
        collect(0);
    endtask

    task automatic test_backpressure();
        issue(3'b001, 32'h0000_00F0, 32'h0000_000F, 4'h3, 1'b0);
        checks++;
        if (rsp_data !== 32'h0000_00FF) begin
            $display("FAIL bp_data: data=%h required 000000ff", rsp_data);
            errors++;
        end
        collect(5);
    endtask

    task automatic test_stat_clr();
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (sticky_c !== 1'b0) begin
            $display("FAIL clr_alone: sticky=%b required 0", sticky_c);
            errors++;
        end
        issue(3'b100, 32'd1, 32'd1, 4'h4, 1'b0);
        checks++;
        if (sticky_c !== 1'b0) begin
            $display("FAIL no_carry_no_set: sticky=%b required 0", sticky_c);
            errors++;
        end
        collect(0);
        issue(3'b101, 32'd1, 32'd2, 4'h6, 1'b1);
        checks++;
        if (sticky_c !== 1'b1 || rsp_flags[2] !== 1'b1) begin
            $display("FAIL set_wins: sticky=%b c=%b required 1 1", sticky_c, rsp_flags[2]);
            errors++;
        end
        collect(0);
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (sticky_c !== 1'b0) begin
            $display("FAIL clr_later: sticky=%b required 0", sticky_c);
            errors++;
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;
        sb.delete();
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            issue(3'b000, 32'd0, $urandom, TAG_W'(i), 1'b0);
            checks++;
            if (rsp_data !== 32'hFFFF_FFFF || rsp_flags !== 3'b001) begin
                $display("FAIL wrap_op: op %0d data=%h flags=%b required ffffffff 001", i, rsp_data, rsp_flags);
                errors++;
            end
            collect(0);
        end
        checks++;
        if (op_count !== 4'd1) begin
            $display("FAIL wrap_count: op_count=%0d required 1", op_count);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_add();
        test_div0();
        test_backpressure();
        test_stat_clr();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
